// File: rtl/rbt_s_phv_pkg.sv
// Shared PHV layout, SEADP header geometry and
// sideband bundles for the SEADP parser slice.
package rbt_s_phv_pkg;

  localparam int PHV_W_PROTO_NO = 0;
  localparam int PHV_W_PKT_NUM  = 2;
  localparam int PHV_W_OFFSET   = 3;
  localparam int PHV_H_SRC_PORT = 0;
  localparam int PHV_H_DST_PORT = 1;
  localparam int PHV_B_FLAGS    = 5;

  localparam int SEADP_TAG_INDEX = 12;
  localparam int ERROR_TAG_INDEX = 31;
  localparam int SEADP_MIN_LEN   = 14;

  localparam int SRC_PORT_OFF = 0;
  localparam int SRC_PORT_W   = 16;
  localparam int DST_PORT_OFF = 16;
  localparam int DST_PORT_W   = 16;
  localparam int FLAGS_OFF    = 32;
  localparam int FLAGS_W      = 8;
  localparam int HDR_LEN_OFF  = 40;
  localparam int HDR_LEN_W    = 8;
  localparam int PKT_NUM_OFF  = 48;
  localparam int PKT_NUM_W    = 32;
  localparam int OFFSET_OFF   = 80;
  localparam int OFFSET_W     = 32;

  typedef struct packed {
    logic [SRC_PORT_W-1:0] src_port;
    logic [DST_PORT_W-1:0] dst_port;
    logic [FLAGS_W-1:0]    flags;
    logic [HDR_LEN_W-1:0]  hdr_len;
    logic [PKT_NUM_W-1:0]  pkt_num;
    logic [OFFSET_W-1:0]   offset;
  } seadp_hdr_t;

  typedef struct packed {
    logic       seadp;
    logic       err;
    seadp_hdr_t hdr;
  } seadp_side_t;

  typedef struct packed {
    logic seadp;
    logic err;
  } seadp_tag_t;

endpackage

// File: rtl/rbt_s_pipe_stage.sv
// Generic valid/ready register slice.
// Ports: clk_i/rst_i, upstream valid_i/ready_o/data_i,
// downstream valid_o/ready_i/data_o.
module rbt_s_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Empty slots always advance; full ones only
  // when the next stage takes the beat.
  assign ready_o = !valid_q | ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_i;
    end
  end

endmodule

// File: rtl/rbt_s_seadp_parser.sv
// SEADP transport parser: extracts fields into the PHV,
// strips the header from data/length, flags malformed
// headers; non-SEADP beats pass through. Ports:
// in_proto_hdr_* (valid/ready/data/length/phv) upstream,
// out_proto_hdr_* downstream, stat_* beat counters.
module rbt_s_seadp_parser #(
  parameter int HEADER_WIDTH  = 2048,
  parameter int PHV_WIDTH     = 408,
  parameter int PHV_B_NUM     = 7,
  parameter int PHV_H_NUM     = 2,
  parameter int PHV_W_NUM     = 10,
  parameter int SEADP_MIN_LEN = rbt_s_phv_pkg::SEADP_MIN_LEN,
  parameter int STAT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_proto_hdr_valid,
  output logic                    in_proto_hdr_ready,
  input  logic [HEADER_WIDTH-1:0] in_proto_hdr_data,
  input  logic [15:0]             in_proto_hdr_length,
  input  logic [PHV_WIDTH-1:0]    in_proto_hdr_phv,
  output logic                    out_proto_hdr_valid,
  input  logic                    out_proto_hdr_ready,
  output logic [HEADER_WIDTH-1:0] out_proto_hdr_data,
  output logic [15:0]             out_proto_hdr_length,
  output logic [PHV_WIDTH-1:0]    out_proto_hdr_phv,
  output logic [STAT_WIDTH-1:0]   stat_seadp_pkts,
  output logic [STAT_WIDTH-1:0]   stat_err_pkts
);

  import rbt_s_phv_pkg::*;

  localparam int H_BASE = 8 * PHV_B_NUM;
  localparam int W_BASE = H_BASE + 16 * PHV_H_NUM;
  localparam int PHV_SUM = W_BASE + 32 * PHV_W_NUM;
  localparam int HW = HEADER_WIDTH;
  localparam int SIDE_W = $bits(seadp_side_t);
  localparam int TAG_W = $bits(seadp_tag_t);
  localparam int S1_W = HW + 16 + PHV_WIDTH + SIDE_W;
  localparam int S2_W = HW + 16 + PHV_WIDTH + TAG_W;
  localparam logic [7:0] MIN_LEN = 8'(SEADP_MIN_LEN);

  localparam int SEADP_BIT =
    W_BASE + 32 * PHV_W_PROTO_NO + SEADP_TAG_INDEX;
  localparam int ERR_BIT =
    W_BASE + 32 * PHV_W_PROTO_NO + ERROR_TAG_INDEX;

  if (PHV_WIDTH != PHV_SUM) begin : g_phv_width_bad
    $error("PHV_WIDTH disagrees with container counts");
  end

  // Stage 1 decode, straight off the input bus.
  seadp_side_t side_d;

  always_comb begin
    side_d = '0;
    side_d.seadp = in_proto_hdr_phv[SEADP_BIT];
    side_d.hdr.src_port =
      in_proto_hdr_data[HW-1-SRC_PORT_OFF -: SRC_PORT_W];
    side_d.hdr.dst_port =
      in_proto_hdr_data[HW-1-DST_PORT_OFF -: DST_PORT_W];
    side_d.hdr.flags =
      in_proto_hdr_data[HW-1-FLAGS_OFF -: FLAGS_W];
    side_d.hdr.hdr_len =
      in_proto_hdr_data[HW-1-HDR_LEN_OFF -: HDR_LEN_W];
    side_d.hdr.pkt_num =
      in_proto_hdr_data[HW-1-PKT_NUM_OFF -: PKT_NUM_W];
    side_d.hdr.offset =
      in_proto_hdr_data[HW-1-OFFSET_OFF -: OFFSET_W];
    side_d.err = (side_d.hdr.hdr_len < MIN_LEN) |
      ({8'd0, side_d.hdr.hdr_len} > in_proto_hdr_length);
  end

  logic            s1_ready;
  logic            s1_valid;
  logic [S1_W-1:0] s1_bus;
  logic            s2_ready;

  rbt_s_pipe_stage #(.W(S1_W)) u_s1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (in_proto_hdr_valid),
    .ready_o (s1_ready),
    .data_i  ({in_proto_hdr_data, in_proto_hdr_length,
               in_proto_hdr_phv, side_d}),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_bus)
  );

  assign in_proto_hdr_ready = s1_ready & !rst;

  logic [HW-1:0]        s1_data;
  logic [15:0]          s1_len;
  logic [PHV_WIDTH-1:0] s1_phv;
  seadp_side_t          s1_side;

  assign {s1_data, s1_len, s1_phv, s1_side} = s1_bus;

  // Stage 2 rewrite; the shift uses the registered
  // hdr_len so the barrel shifter sits after stage 1.
  logic [HW-1:0]        data_d;
  logic [15:0]          len_d;
  logic [PHV_WIDTH-1:0] phv_d;
  seadp_tag_t           tag_d;
  logic [10:0]          shamt;

  assign shamt = {s1_side.hdr.hdr_len, 3'b000};

  always_comb begin
    data_d = s1_data;
    len_d  = s1_len;
    phv_d  = s1_phv;
    tag_d.seadp = s1_side.seadp;
    tag_d.err   = s1_side.err;
    if (s1_side.seadp) begin
      if (s1_side.err) begin
        data_d = '0;
        len_d  = '0;
        phv_d[ERR_BIT] = 1'b1;
      end else begin
        data_d = s1_data << shamt;
        len_d  = s1_len - {8'd0, s1_side.hdr.hdr_len};
        phv_d[H_BASE + 16*PHV_H_SRC_PORT +: 16] =
          s1_side.hdr.src_port;
        phv_d[H_BASE + 16*PHV_H_DST_PORT +: 16] =
          s1_side.hdr.dst_port;
        phv_d[W_BASE + 32*PHV_W_PKT_NUM +: 32] =
          s1_side.hdr.pkt_num;
        phv_d[W_BASE + 32*PHV_W_OFFSET +: 32] =
          s1_side.hdr.offset;
        phv_d[8*PHV_B_FLAGS +: 8] = s1_side.hdr.flags;
      end
    end
  end

  logic [S2_W-1:0] s2_bus;
  seadp_tag_t      s2_tag;

  rbt_s_pipe_stage #(.W(S2_W)) u_s2 (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  ({data_d, len_d, phv_d, tag_d}),
    .valid_o (out_proto_hdr_valid),
    .ready_i (out_proto_hdr_ready),
    .data_o  (s2_bus)
  );

  assign {out_proto_hdr_data, out_proto_hdr_length,
          out_proto_hdr_phv, s2_tag} = s2_bus;

  // Counters only see SEADP beats leaving the block.
  logic                  done;
  logic [STAT_WIDTH-1:0] ok_q, ok_d;
  logic [STAT_WIDTH-1:0] err_q, err_d;

  assign done = out_proto_hdr_valid &
                out_proto_hdr_ready & s2_tag.seadp;

  always_comb begin
    ok_d  = ok_q;
    err_d = err_q;
    if (done) begin
      if (s2_tag.err) err_d = err_q + 1'b1;
      else            ok_d  = ok_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q  <= '0;
      err_q <= '0;
    end else begin
      ok_q  <= ok_d;
      err_q <= err_d;
    end
  end

  assign stat_seadp_pkts = ok_q;
  assign stat_err_pkts   = err_q;

endmodule

// File: tb/tb_rbt_s_seadp_parser.sv
// Directed bench for the SEADP parser.
// Hand-built beats with hand-derived expectations.
module tb_rbt_s_seadp_parser;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2047:0] in_data;
  logic [15:0]   in_len;
  logic [407:0]  in_phv;
  logic          out_valid, out_ready;
  logic [2047:0] out_data;
  logic [15:0]   out_len;
  logic [407:0]  out_phv;
  logic [31:0]   st_ok, st_err;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [2047:0] bd [0:15];
  logic [15:0]   bl [0:15];
  logic [407:0]  bp [0:15];

  logic          ov;
  logic [2047:0] od;
  logic [15:0]   ol;
  logic [407:0]  op;

  logic [1935:0] pl;
  logic [2047:0] d, ed;
  logic [407:0]  p, ep;
  int            acc;

  always #5 clk = ~clk;

  rbt_s_seadp_parser dut (
    .clk                  (clk),
    .rst                  (rst),
    .in_proto_hdr_valid   (in_valid),
    .in_proto_hdr_ready   (in_ready),
    .in_proto_hdr_data    (in_data),
    .in_proto_hdr_length  (in_len),
    .in_proto_hdr_phv     (in_phv),
    .out_proto_hdr_valid  (out_valid),
    .out_proto_hdr_ready  (out_ready),
    .out_proto_hdr_data   (out_data),
    .out_proto_hdr_length (out_len),
    .out_proto_hdr_phv    (out_phv),
    .stat_seadp_pkts      (st_ok),
    .stat_err_pkts        (st_err)
  );

  function automatic logic [111:0] hdr(
    input logic [15:0] s, input logic [15:0] t,
    input logic [7:0] f, input logic [7:0] h,
    input logic [31:0] n, input logic [31:0] o);
    return {s, t, f, h, n, o};
  endfunction

  function automatic logic [407:0] setw(
    input logic [407:0] v, input int i, input logic [31:0] x);
    v[88 + 32*i +: 32] = x;
    return v;
  endfunction

  function automatic logic [407:0] seth(
    input logic [407:0] v, input int i, input logic [15:0] x);
    v[56 + 16*i +: 16] = x;
    return v;
  endfunction

  function automatic logic [407:0] setb(
    input logic [407:0] v, input int i, input logic [7:0] x);
    v[8*i +: 8] = x;
    return v;
  endfunction

  task automatic chk32(input string tag,
    input logic [31:0] o, input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  task automatic chkw(input string tag,
    input logic [2047:0] o, input logic [2047:0] e);
    ntot++;
    assert (o === e) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got(lo128) %h want(lo128) %h",
             tag, o[127:0], e[127:0]);
    end
  endtask

  // One beat through an empty pipe with out_ready high;
  // captures the output two edges after acceptance.
  task automatic xfer(input logic [2047:0] dd,
    input logic [15:0] ll, input logic [407:0] pp);
    in_valid = 1'b1;
    in_data  = dd;
    in_len   = ll;
    in_phv   = pp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    ov = out_valid;
    od = out_data;
    ol = out_len;
    op = out_phv;
    @(posedge clk); #1;
  endtask

  task automatic run_stream(input int n,
    input int sent0, input bit toggle);
    int sent;
    int rcv;
    bit held;
    logic [2047:0] hd;
    logic [15:0] hl;
    sent = sent0;
    rcv  = 0;
    held = 1'b0;
    hd   = '0;
    hl   = '0;
    for (int c = 0; c < 400 && rcv < n; c++) begin
      @(negedge clk);
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      in_valid = (sent < n);
      if (sent < n) begin
        in_data = bd[sent];
        in_len  = bl[sent];
        in_phv  = bp[sent];
      end
      #1;
      if (held) begin
        chk32("stall_valid", 32'(out_valid), 32'd1);
        chkw("stall_data", out_data, hd);
        chk32("stall_len", 32'(out_len), 32'(hl));
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        chkw("str_data", out_data, bd[rcv]);
        chk32("str_len", 32'(out_len), 32'(bl[rcv]));
        chkw("str_phv", 2048'(out_phv), 2048'(bp[rcv]));
        rcv++;
      end else if (out_valid) begin
        held = 1'b1;
        hd = out_data;
        hl = out_len;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk32("str_count", 32'(rcv), 32'(n));
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_len = '0;
    in_phv = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk32("rst_in_ready", 32'(in_ready), 32'd0);
    chk32("rst_out_valid", 32'(out_valid), 32'd0);
    chkw("rst_out_data", out_data, '0);
    chk32("rst_out_len", 32'(out_len), 32'd0);
    chkw("rst_out_phv", 2048'(out_phv), '0);
    chk32("rst_st_ok", st_ok, 32'd0);
    chk32("rst_st_err", st_err, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk32("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: good SEADP beat, 14-byte header
    pl = '0;
    pl[1935 -: 64] = 64'h0123_4567_89AB_CDEF;
    pl[15:0] = 16'h5A5A;
    d = {hdr(16'h1234, 16'h5678, 8'hA5, 8'd14,
             32'hDEAD_BEEF, 32'h10), pl};
    ed = {pl, 112'd0};
    p = '0;
    p = setw(p, 0, 32'h0000_1000);
    p = setw(p, 5, 32'h1111_2222);
    p = setb(p, 0, 8'h33);
    ep = seth(p, 0, 16'h1234);
    ep = seth(ep, 1, 16'h5678);
    ep = setw(ep, 2, 32'hDEAD_BEEF);
    ep = setw(ep, 3, 32'h10);
    ep = setb(ep, 5, 8'hA5);
    xfer(d, 16'd100, p);
    chk32("t1_valid", 32'(ov), 32'd1);
    chkw("t1_data", od, ed);
    chk32("t1_len", 32'(ol), 32'd86);
    chkw("t1_phv", 2048'(op), 2048'(ep));
    chk32("t1_st_ok", st_ok, 32'd1);
    chk32("t1_st_err", st_err, 32'd0);

    // 2: non-SEADP beat passes through untouched
    d = {hdr(16'hAAAA, 16'hBBBB, 8'h11, 8'd14,
             32'h1, 32'h2), 1936'h77};
    p = '0;
    p = setw(p, 0, 32'hFFFF_EFFF);
    p = seth(p, 1, 16'h4321);
    xfer(d, 16'd40, p);
    chk32("t2_valid", 32'(ov), 32'd1);
    chkw("t2_data", od, d);
    chk32("t2_len", 32'(ol), 32'd40);
    chkw("t2_phv", 2048'(op), 2048'(p));
    chk32("t2_st_ok", st_ok, 32'd1);
    chk32("t2_st_err", st_err, 32'd0);

    // 3: short header, then header longer than length
    p = setw('0, 0, 32'h0000_1000);
    p = setw(p, 7, 32'hCAFE_0001);
    ep = setw(p, 0, 32'h8000_1000);
    d = {hdr(16'h1, 16'h2, 8'h3, 8'd8,
             32'h4, 32'h5), 1936'hFF};
    xfer(d, 16'd100, p);
    chk32("t3a_valid", 32'(ov), 32'd1);
    chkw("t3a_data", od, '0);
    chk32("t3a_len", 32'(ol), 32'd0);
    chkw("t3a_phv", 2048'(op), 2048'(ep));
    d = {hdr(16'h1, 16'h2, 8'h3, 8'd60,
             32'h4, 32'h5), 1936'hFF};
    xfer(d, 16'd50, p);
    chkw("t3b_data", od, '0);
    chk32("t3b_len", 32'(ol), 32'd0);
    chkw("t3b_phv", 2048'(op), 2048'(ep));
    chk32("t3_st_err", st_err, 32'd2);
    chk32("t3_st_ok", st_ok, 32'd1);

    // hdr_len equal to length is legal, all stripped
    d = {hdr(16'h9, 16'h8, 8'h7, 8'd20,
             32'h6, 32'h5), 48'hFEED_FACE_1234, 1888'd0};
    p = setw('0, 0, 32'h0000_1000);
    xfer(d, 16'd20, p);
    chkw("eq_data", od, '0);
    chk32("eq_len", 32'(ol), 32'd0);
    chk32("eq_errbit", 32'(op[88+31]), 32'd0);
    chk32("eq_st_ok", st_ok, 32'd2);

    // hdr_len 0 is malformed
    d = {hdr(16'h9, 16'h8, 8'h7, 8'd0,
             32'h6, 32'h5), 1936'h3};
    xfer(d, 16'd30, p);
    chk32("z_errbit", 32'(op[88+31]), 32'd1);
    chk32("z_len", 32'(ol), 32'd0);
    chk32("z_st_err", st_err, 32'd3);

    // 4: 16 beats, out_ready toggling
    for (int i = 0; i < 16; i++) begin
      bd[i] = '0;
      bd[i][2047 -: 32] = 32'hA000_0000 + i;
      bd[i][31:0] = ~32'(i);
      bl[i] = 16'(40 + i);
      bp[i] = setb('0, 0, 8'(i));
      bp[i] = setw(bp[i], 1, 32'h5000_0000 + i);
    end
    run_stream(16, 0, 1'b1);
    chk32("t4_st_ok", st_ok, 32'd2);

    // 5: downstream stalled, only two slots fill
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (acc < 3);
      in_data = bd[acc];
      in_len = bl[acc];
      in_phv = bp[acc];
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    #1;
    chk32("t5_accepted", 32'(acc), 32'd2);
    chk32("t5_in_ready", 32'(in_ready), 32'd0);
    run_stream(3, 2, 1'b0);

    // 6: reset with two beats in flight
    @(posedge clk); #1;
    d = {hdr(16'h1, 16'h2, 8'h3, 8'd14,
             32'h4, 32'h5), 1936'h1};
    p = setw('0, 0, 32'h0000_1000);
    in_valid = 1'b1;
    in_data = d;
    in_len = 16'd50;
    in_phv = p;
    @(posedge clk); #1;
    in_data = ~d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk32("t6_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk32("t6_valid0", 32'(out_valid), 32'd0);
    chk32("t6_st_ok", st_ok, 32'd0);
    chk32("t6_st_err", st_err, 32'd0);
    @(posedge clk); #1;
    chk32("t6_valid1", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk32("t6_lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk32("t6_lat2", 32'(out_valid), 32'd1);
    chk32("t6_len", 32'(out_len), 32'd36);
    @(posedge clk); #1;
    chk32("t6_st_ok2", st_ok, 32'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
